pipe_dmem_stage: RTL
====================

# pipe_dmem_stage

Parametrised, multi-cycle data-memory stage for the Y86-64 pipeline, sitting between the M and W pipeline registers. It decodes the memory-touching icodes and range-checks the effective address. It performs the access after a configurable latency and drives `m_stall` to pipeline control while the access is outstanding. It replaces the single-cycle, fixed-size memory stage with a synchronous, resettable block of configurable width and depth.

## Interface
- `WIDTH`, 64: data word width in bits; `M_ValA`, `M_ValE` and `m_ValM` use this width.
- `DEPTH`, 1024: number of words; word-addressed, valid index range 0..DEPTH-1.
- `LATENCY`, 2: busy cycles per access, legal range 1..15.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `M_icode` in 4: icode held in the M register.
- `M_stat` in 4: status held in the M register.
- `M_ValA` in WIDTH: signed; store data for 4/8/10; address for 9/11.
- `M_ValE` in WIDTH: signed; address for 4/5/8/10.
- `m_ValM` out WIDTH: read data, registered.
- `m_stat` out 4: status forwarded to the W register.
- `dmem_err` out 1: address out of range for the current memory op.
- `m_stall` out 1: holds the F/D/E/M registers; forces a bubble into W.

## Operation
- Write ops: RMMOVQ 4, CALL 8, PUSHQ 10; address `M_ValE`, data `M_ValA`.
- Read ops: MRMOVQ 5 (address `M_ValE`); RET 9 and POPQ 11 (address `M_ValA`).
- All other icodes: no access, no stall, `dmem_err`=0.
- Address legal iff 0 <= addr < DEPTH, with addr taken as a full-width signed value. Legal addresses are truncated to ADDR_W=$clog2(DEPTH) bits.
- `dmem_err` is combinational: 1 iff the icode is a memory op and its address is illegal.
- `m_stat`: SADR (3) when `dmem_err`=1; otherwise `M_stat`, passed through combinationally.
- An access starts only when icode is a memory op, `dmem_err`=0 and `M_stat`=SAOK (1). Bubbles and HLT/INS/ADR instructions never touch memory.
- FSM states and transitions:
  - IDLE: on a start condition, latch op, address and data; load count=LATENCY; go to BUSY.
  - BUSY: decrement count. When count==1, perform the write, or capture the read word into `m_ValM`; go to DONE.
  - DONE: go to IDLE unconditionally.
- `m_stall`=1 in IDLE when the start condition is true, and in every BUSY cycle; 0 in DONE and otherwise.
- The access uses only the latched copies. Input changes during BUSY are ignored.
- `m_ValM` holds its last read value across writes, non-memory ops and errors.
- Illegal address: no access, no stall, no state change; the instruction leaves M in one cycle carrying SADR.

## Timing
- A memory op occupies M for LATENCY+2 cycles: one accept cycle, LATENCY BUSY cycles, then DONE.
- `m_stall` is high for LATENCY+1 cycles.
- Read data is valid in `m_ValM` in the DONE cycle, coincident with the `m_stall` fall. W captures it at that edge.
- The write commits at the rising edge that ends the final BUSY cycle.
- Back-to-back memory ops: the next op is evaluated in the IDLE cycle after DONE, so each op costs LATENCY+2 cycles.
- Reset values: FSM=IDLE, count=0, `m_ValM`=0, `m_stall`=0, all performance counters=0. Memory contents are not cleared.
- Reset during BUSY: abort immediately, perform no write, `m_stall` falls asynchronously.

## Configuration
- `DMEM_PERF_EN` defined:
  - Adds outputs `perf_rd` (32), `perf_wr` (32), `perf_err` (32) and `perf_stall` (32).
  - `perf_rd` and `perf_wr` increment at each read or write commit.
  - `perf_err` increments each cycle `dmem_err`=1 while `M_stat`=SAOK.
  - `perf_stall` increments each cycle `m_stall`=1.
  - All four saturate at 32'hFFFF_FFFF and reset to 0.
- `DMEM_PERF_EN` undefined: these ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `y86_pkg` holds:
  - icode constants: IRMMOVQ=4, IMRMOVQ=5, ICALL=8, IRET=9, IPUSHQ=10, IPOPQ=11;
  - stat codes: SAOK=1, SHLT=2, SADR=3, SINS=4;
  - the FSM state enum.
- Sub-module `dmem_array`: single-port WIDTH x DEPTH RAM with synchronous write-enable and a registered read port, instantiated once. The FSM, range check and counters stay in the top level.

## Test plan
- LATENCY=2, RMMOVQ with ValE=5, ValA=0x1234, then MRMOVQ with ValE=5:
  - `m_stall` high for 3 cycles per op;
  - `m_ValM`=0x1234 in the second op's DONE cycle.
- MRMOVQ with ValE=1024 (DEPTH=1024): `dmem_err`=1, `m_stat`=3, `m_stall`=0, `m_ValM` unchanged, no write.
- POPQ with ValA=-8: `dmem_err`=1 and `m_stat`=3. Then RET with ValA=0 (word 0 preloaded 0xAA): `m_ValM`=0xAA.
- PUSHQ with ValE=7 and `M_stat`=SINS: no stall, no write, word 7 unchanged, `m_stat`=4.
- PUSHQ with ValE=9 and `rst` pulsed in the second BUSY cycle: `m_stall` drops immediately, FSM=IDLE, word 9 unchanged.
- With `DMEM_PERF_EN`, LATENCY=3, two reads, one write and one error: `perf_rd`=2, `perf_wr`=1, `perf_err`=1, `perf_stall`=12.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: Y86-64 icode/stat constants and data-memory stage FSM state type.
package y86_pkg;
  localparam logic [3:0] IRMMOVQ = 4'd4;
  localparam logic [3:0] IMRMOVQ = 4'd5;
  localparam logic [3:0] ICALL   = 4'd8;
  localparam logic [3:0] IRET    = 4'd9;
  localparam logic [3:0] IPUSHQ  = 4'd10;
  localparam logic [3:0] IPOPQ   = 4'd11;
  localparam logic [3:0] SAOK = 4'd1;
  localparam logic [3:0] SHLT = 4'd2;
  localparam logic [3:0] SADR = 4'd3;
  localparam logic [3:0] SINS = 4'd4;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} dmem_state_e;
  function automatic logic is_wr_op(input logic [3:0] icode);
    return icode == IRMMOVQ || icode == ICALL || icode == IPUSHQ;
  endfunction
  function automatic logic is_rd_op(input logic [3:0] icode);
    return icode == IMRMOVQ || icode == IRET || icode == IPOPQ;
  endfunction
endpackage

// File: rtl/pipe_dmem_stage_if.sv
// pipe_dmem_stage_if: M-register inputs and memory-stage results between pipeline and data-memory stage.
interface pipe_dmem_stage_if #(parameter int WIDTH = 64);
  logic [3:0] M_icode;
  logic [3:0] M_stat;
  logic [WIDTH-1:0] M_ValA;
  logic [WIDTH-1:0] M_ValE;
  logic [WIDTH-1:0] m_ValM;
  logic [3:0] m_stat;
  logic dmem_err;
  logic m_stall;
  modport master (output M_icode, M_stat, M_ValA, M_ValE, input m_ValM, m_stat, dmem_err, m_stall);
  modport slave (input M_icode, M_stat, M_ValA, M_ValE, output m_ValM, m_stat, dmem_err, m_stall);
endinterface

// File: rtl/dmem_array.sv
// dmem_array: single-port WIDTH x DEPTH RAM, synchronous write, registered read.
module dmem_array #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/pipe_dmem_stage.sv
// pipe_dmem_stage: multi-cycle Y86-64 data-memory stage with range check and pipeline stall.
// Define DMEM_PERF_EN to add saturating read/write/error/stall performance counters.
module pipe_dmem_stage
  import y86_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic rst,
  pipe_dmem_stage_if.slave bus
`ifdef DMEM_PERF_EN
  ,
  output logic [31:0] perf_rd,
  output logic [31:0] perf_wr,
  output logic [31:0] perf_err,
  output logic [31:0] perf_stall
`endif
);
  localparam int ADDR_W = $clog2(DEPTH);
  dmem_state_e state, state_nx;
  logic wr_op, rd_op, start, last, lat_wr;
  logic [WIDTH-1:0] addr, lat_data, rdata;
  logic [ADDR_W-1:0] lat_addr, ram_addr;
  logic [3:0] cnt;
  assign wr_op = is_wr_op(bus.M_icode);
  assign rd_op = is_rd_op(bus.M_icode);
  assign addr = (bus.M_icode == IRET || bus.M_icode == IPOPQ) ? bus.M_ValA : bus.M_ValE;
  // negative addresses read as huge unsigned values, so one compare covers both bounds
  assign bus.dmem_err = (wr_op || rd_op) && addr >= WIDTH'(DEPTH);
  assign bus.m_stat = bus.dmem_err ? SADR : bus.M_stat;
  assign start = state == IDLE && (wr_op || rd_op) && !bus.dmem_err && bus.M_stat == SAOK;
  assign last = state == BUSY && cnt == 4'd1;
  // present the live address while accepting so read data is ready in the first BUSY cycle
  assign ram_addr = state == IDLE ? addr[ADDR_W-1:0] : lat_addr;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = start ? BUSY : last ? DONE : state == DONE ? IDLE : state;
    bus.m_stall = !rst && (start || state == BUSY);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      lat_wr <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
      bus.m_ValM <= '0;
    end else begin
      if (start) begin
        lat_wr <= wr_op;
        lat_addr <= addr[ADDR_W-1:0];
        lat_data <= bus.M_ValA;
        cnt <= 4'(LATENCY);
      end else if (state == BUSY) cnt <= cnt - 4'd1;
      if (last && !lat_wr) bus.m_ValM <= rdata;
    end
  dmem_array #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .we(last && lat_wr),
    .addr(ram_addr),
    .wdata(lat_data),
    .rdata(rdata)
  );
`ifdef DMEM_PERF_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      perf_rd <= '0;
      perf_wr <= '0;
      perf_err <= '0;
      perf_stall <= '0;
    end else begin
      if (last && !lat_wr && perf_rd != '1) perf_rd <= perf_rd + 32'd1;
      if (last && lat_wr && perf_wr != '1) perf_wr <= perf_wr + 32'd1;
      if (bus.dmem_err && bus.M_stat == SAOK && perf_err != '1) perf_err <= perf_err + 32'd1;
      if (bus.m_stall && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
    end
`endif
endmodule
